// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers, multiply-accumulate and
// independent multiply and divide latencies for the E stage.
module mdu_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_skip;

    logic signed [PW-1:0]    op_a_s;
    logic signed [PW-1:0]    op_b_s;
    logic signed [PW-1:0]    prod_s_raw;
    logic [PW-1:0]           prod_s;
    logic [PW-1:0]           prod_u;
    logic [PW-1:0]           acc;
    logic [PW-1:0]           res_next;
    logic signed [WIDTH-1:0] sdividend;
    logic signed [WIDTH-1:0] sdivisor;
    logic signed [WIDTH-1:0] quo_s;
    logic signed [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0]        udivisor;
    logic [WIDTH-1:0]        quo_u;
    logic [WIDTH-1:0]        rem_u;
    logic                    div_zero;
    logic                    div_ovf;
    logic                    is_div;
    logic                    is_long;
    logic                    accept;
    logic [CNT_W-1:0]        cnt_load;

    // Result of the op presented this cycle; latched only on acceptance.
    always_comb begin
        op_a_s     = {{WIDTH{d1[WIDTH-1]}}, d1};
        op_b_s     = {{WIDTH{d2[WIDTH-1]}}, d2};
        prod_s_raw = op_a_s * op_b_s;
        prod_s     = prod_s_raw;
        prod_u     = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
        acc        = {hi, lo};

        div_zero  = (d2 == '0);
        div_ovf   = (d1 == {1'b1, {(WIDTH-1){1'b0}}}) && (d2 == '1);
        sdividend = d1;
        // Dividing by one yields the required overflow result (LO=d1, HI=0).
        sdivisor  = (div_zero || div_ovf) ? WIDTH'(1) : d2;
        quo_s     = sdividend / sdivisor;
        rem_s     = sdividend % sdivisor;
        udivisor  = div_zero ? WIDTH'(1) : d2;
        quo_u     = d1 / udivisor;
        rem_u     = d1 % udivisor;

        res_next = acc;
        case (op)
            OP_MULT:  res_next = prod_s;
            OP_MULTU: res_next = prod_u;
            OP_DIV:   res_next = {rem_s, quo_s};
            OP_DIVU:  res_next = {rem_u, quo_u};
            OP_MADD:  res_next = acc + prod_s;
            OP_MADDU: res_next = acc + prod_u;
            OP_MSUB:  res_next = acc - prod_s;
            OP_MSUBU: res_next = acc - prod_u;
            default:  res_next = acc;
        endcase

        is_div   = (op == OP_DIV) || (op == OP_DIVU);
        is_long  = (op >= OP_MULT) && (op <= OP_MSUBU);
        accept   = start && !req && !busy;
        cnt_load = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_skip <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept && is_long) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= cnt_load;
                        done     <= (cnt_load == CNT_W'(1));
                        res_hi   <= res_next[PW-1:WIDTH];
                        res_lo   <= res_next[WIDTH-1:0];
                        res_skip <= is_div && div_zero;
                    end else if (accept && op == OP_MTHI) begin
                        hi <= d1;
                    end else if (accept && op == OP_MTLO) begin
                        lo <= d1;
                    end
                end
                RUN: begin
                    // done is raised one edge early so it is high in the final busy cycle.
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        cnt   <= '0;
                        if (!res_skip) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt  <= cnt - CNT_W'(1);
                        done <= (cnt == CNT_W'(2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a 32-bit default instance plus a 16-bit,
// single-cycle-multiply instance.
module tb_mdu_unit;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;
    localparam logic [3:0] OP_MADDU = 4'd6;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, req, start_a, start_b;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] hi_a, lo_a;
    logic [15:0] hi_b, lo_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mdu_unit u_a (
        .clk   (clk),
        .reset (rst_a),
        .req   (req),
        .start (start_a),
        .op    (op),
        .d1    (d1),
        .d2    (d2),
        .busy  (busy_a),
        .done  (done_a),
        .hi    (hi_a),
        .lo    (lo_a)
    );

    mdu_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .req   (req),
        .start (start_b),
        .op    (op),
        .d1    (d1[15:0]),
        .d2    (d2[15:0]),
        .busy  (busy_b),
        .done  (done_b),
        .hi    (hi_b),
        .lo    (lo_b)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    // inj_kind: 0 none, 1 mthi start during busy, 2 req pulse during busy, 3 req with the start
    task automatic run_op(input string name, input bit sel, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int ncyc, input int inj_at, input int inj_kind);
        int   cyc, ndone, done_pos;
        logic bz, dn, done_ok;
        @(negedge clk);
        op = o; d1 = a; d2 = b; req = (inj_kind == 3);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; req = 1'b0;
        cyc = 0; ndone = 0; done_pos = 0;
        for (int g = 0; g < 100; g++) begin
            bz = sel ? busy_b : busy_a;
            if (!bz) break;
            dn = sel ? done_b : done_a;
            cyc++;
            if (dn) begin ndone++; done_pos = cyc; end
            if (cyc == inj_at && inj_kind == 1) begin
                op = OP_MTHI; d1 = 32'hDEAD;
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end else if (cyc == inj_at && inj_kind == 2) begin
                req = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0; req = 1'b0;
            end
            @(negedge clk);
        end
        start_a = 1'b0; start_b = 1'b0; req = 1'b0;
        dn = sel ? done_b : done_a;
        done_ok = (ndone == ((ncyc != 0) ? 1 : 0)) && (done_pos == ncyc) && !dn;
        check({name, " busy_cycles"}, 32'(cyc), 32'(ncyc));
        check({name, " done_pulse"}, {31'b0, done_ok}, 32'd1);
        check({name, " hi"}, sel ? {16'b0, hi_b} : hi_a, eh);
        check({name, " lo"}, sel ? {16'b0, lo_b} : lo_a, el);
    endtask

    initial begin
        logic seen_done;
        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 10};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{OP_MTHI,  32'h0,         32'd0,        32'h0000_0000, 32'hFFFF_FFFD, 0};
        vecs[4]  = '{OP_MTLO,  32'hFFFF_FFFF, 32'd0,        32'h0000_0000, 32'hFFFF_FFFF, 0};
        vecs[5]  = '{OP_MADDU, 32'd1,         32'd1,        32'h0000_0001, 32'h0000_0000, 5};
        vecs[6]  = '{OP_MSUB,  32'd2,         32'd1,        32'h0000_0000, 32'hFFFF_FFFE, 5};
        vecs[7]  = '{OP_MTHI,  32'h11,        32'd0,        32'h0000_0011, 32'hFFFF_FFFE, 0};
        vecs[8]  = '{OP_MTLO,  32'h22,        32'd0,        32'h0000_0011, 32'h0000_0022, 0};
        vecs[9]  = '{OP_DIV,   32'd5,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
        vecs[10] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[11] = '{OP_MADD,  32'hFFFF_FFFF, 32'd2,        32'h0000_0000, 32'h7FFF_FFFE, 5};
        vecs[12] = '{OP_MSUBU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 32'h8000_0000, 5};
        vecs[13] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[14] = '{4'd11,    32'h1234,      32'h5678,     32'hFFFF_FFFE, 32'h0000_0001, 0};

        rst_a = 1'b1; rst_b = 1'b1; req = 1'b0; start_a = 1'b0; start_b = 1'b0;
        op = 4'd0; d1 = '0; d2 = '0;
        repeat (3) @(negedge clk);
        check("reset busy_a", {31'b0, busy_a}, 32'd0);
        check("reset done_a", {31'b0, done_a}, 32'd0);
        check("reset hi_a", hi_a, 32'd0);
        check("reset lo_a", lo_a, 32'd0);
        check("reset busy_b", {31'b0, busy_b}, 32'd0);
        check("reset hi_b", {16'b0, hi_b}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), 1'b0, vecs[i].op, vecs[i].d1, vecs[i].d2,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc, 0, 0);

        run_op("req_start",     1'b0, OP_MULT, 32'd2,   32'd3, 32'hFFFF_FFFE, 32'h1, 0, 0, 3);
        run_op("start_in_busy", 1'b0, OP_MULT, 32'd2,   32'd3, 32'd0, 32'd6, 5, 2, 1);
        run_op("req_mid_run",   1'b0, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, 4, 2);

        // Reset asserted in the third busy cycle aborts the multiply.
        @(negedge clk);
        op = OP_MULT; d1 = 32'd5; d2 = 32'd5; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (done_a) seen_done = 1'b1;
            if (k < 3) @(negedge clk);
        end
        check("rst_mid busy_before", {31'b0, busy_a}, 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("rst_mid busy", {31'b0, busy_a}, 32'd0);
        check("rst_mid done", {31'b0, done_a | seen_done}, 32'd0);
        check("rst_mid hi", hi_a, 32'd0);
        check("rst_mid lo", lo_a, 32'd0);
        run_op("after_rst", 1'b0, OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25, 5, 0, 0);

        run_op("w16_mult", 1'b1, OP_MULT, 32'hFFFE, 32'd3, 32'hFFFF, 32'hFFFA, 1, 0, 0);
        run_op("w16_divu", 1'b1, OP_DIVU, 32'd7,    32'd2, 32'h1,    32'h3,    3, 0, 0);
        run_op("w16_div",  1'b1, OP_DIV,  32'hFFF9, 32'd2, 32'hFFFF, 32'hFFFD, 3, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It replaces the fixed-width, fixed-latency HI/LO unit with one that has configurable operand width and independent multiply and divide latencies. It adds multiply-accumulate (madd/maddu/msub/msubu), a one-cycle `done` pulse, and defined results for divide-by-zero and signed overflow. The stall controller reads `start`/`busy`, and the E-stage GRF write-data mux reads `hi`/`lo` directly for mfhi/mflo.

## Interface
- `WIDTH`, 32: operand, HI and LO width (≥ 8).
- `MUL_CYCLES`, 5: busy cycles for mult/multu/madd/maddu/msub/msubu (≥ 1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥ 1).

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: exception/interrupt request from CP0; when high, the start of the current cycle is suppressed.
- `start` in 1: strobe qualifying `op` for one cycle.
- `op` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; codes 11–15 are reserved and act as none.
- `d1` in WIDTH: rs operand, already forwarded; source of mthi/mtlo.
- `d2` in WIDTH: rt operand, already forwarded.
- `busy` out 1: a multi-cycle operation is in flight.
- `done` out 1: one-cycle pulse in the final busy cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **States.** IDLE and RUN. `busy = (state == RUN)`.
- **Accepted start.** A start is accepted when `start & ~req & ~busy` and `op` is 1–10.
  - Ops 1–8: latch the result into internal `res_hi`/`res_lo`, load the counter with `MUL_CYCLES` or `DIV_CYCLES`, and go to RUN.
  - Ops 9–10: write `d1` into HI or LO at that edge; stay in IDLE. No busy, no done.
- **Ignored start.** A start is ignored entirely when `busy=1` (protocol violation; the stall controller prevents it) or when `req=1`.
- **Arithmetic.** All results are computed at acceptance from the operands at that cycle and, for accumulate ops, from HI/LO at that cycle.
  - mult/multu: {HI,LO} = 2·WIDTH-bit signed/unsigned product.
  - madd(u)/msub(u): {HI,LO} = {HI,LO} ± product, modulo 2^(2·WIDTH).
  - div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (d1 = −2^(WIDTH−1), d2 = −1): LO = d1, HI = 0.
  - Divide-by-zero (d2 = 0): the operation still occupies `DIV_CYCLES` busy cycles, but HI and LO are left unchanged.
- **RUN.** The counter decrements every cycle. When the counter equals 1: `done=1`, HI/LO are written from `res_hi`/`res_lo` (unless the op is divide-by-zero), and the next state is IDLE.
- **req during RUN.** Has no effect. The in-flight op belongs to an instruction that has already passed E, so it completes.
- **Reset.** State IDLE, counter 0, `hi=0`, `lo=0`, `busy=0`, `done=0`, `res_*=0`. Asserting reset mid-RUN aborts the op; HI/LO are 0 at the next cycle.
- **Reads.** `hi`/`lo` always show the committed registers, never the pending result.

## Timing
- **Start timing.** Start accepted at cycle t:
  - `busy=1` during cycles t+1 … t+N, where N = MUL_CYCLES or DIV_CYCLES.
  - `done=1` only in cycle t+N.
  - New HI/LO are visible in cycle t+N+1, with `busy=0`.
- **Back-to-back.** The next start may be accepted in cycle t+N+1. No dead cycle is required.
- **mthi/mtlo.** Accepted at t; the new value is visible at t+1.
- **Stall rule.** The stall controller must stall any mult/div/mf/mt op in D while `E_start | busy`. The unit itself provides no ordering.
- **N = 1.** `busy` and `done` are both high for exactly cycle t+1.
- **Outputs.** `busy`, `done`, `hi` and `lo` are all registered; there is no combinational path from inputs to outputs.

## Test plan
- **Signed multiply.** Reset; start mult with d1=0xFFFF_FFFE, d2=3 (WIDTH=32, MUL_CYCLES=5).
  - `busy` is high for 5 cycles and `done` pulses in the 5th.
  - Afterwards hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- **Signed divide.** divu then div with d1=0xFFFF_FFF9 (−7), d2=2:
  - divu: lo=0x7FFF_FFFC, hi=1.
  - div: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - Each shows `busy` for exactly 10 cycles.
- **Accumulate and move.** mthi 0, mtlo 0xFFFF_FFFF, then maddu with d1=1, d2=1 → hi=1, lo=0. Then msub with d1=2, d2=1 → hi=0, lo=0xFFFF_FFFE.
- **Divide edge cases.**
  - hi=0x11, lo=0x22 preloaded, then div with d2=0 → 10 busy cycles, HI/LO unchanged.
  - div with d1=0x8000_0000, d2=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- **Suppressed starts.**
  - start with req=1 → no busy, HI/LO unchanged.
  - A start during busy is ignored, and the original result still commits.
  - req pulsing mid-RUN does not alter the result.
- **Reset mid-operation and parameter sweep.**
  - Reset in busy cycle 3 → busy=0, hi=lo=0 next cycle, and no done pulse.
  - Repeat the mult case with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3: 0xFFFE×3 → hi=0xFFFF, lo=0xFFFA after 1 busy cycle.
